store_drain_buffer: RTL and testbench

- Responder for the commit-side data-cache write port: accepts the masked word stores the reorder buffer retires on dcache_write / dcache_mask / dcache_addr / dcache_data.
- Returns dcache_write_valid as the ready flag; the reorder buffer stalls its commit head while this flag is low.
- Buffers accepted stores in an in-order FIFO and drains them one at a time to the memory/cache array over a req/ack handshake.
- Gives the load unit a same-word hazard check against every store not yet written.

---
 rtl/store_drain_buffer_pkg.sv | 35 +++
 rtl/store_drain_buffer_fifo.sv | 96 +++++++++
 rtl/store_drain_buffer.sv | 136 +++++++++++++
 tb/tb_store_drain_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_drain_buffer_pkg.sv
// Shared widths, depth and drain-FSM encodings for the store drain buffer.
`ifndef Addr_Width
`define Addr_Width 32
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef SDB_Depth
`define SDB_Depth 4
`endif
`ifndef SDB_IDLE
`define SDB_IDLE 2'd0
`endif
`ifndef SDB_REQ
`define SDB_REQ 2'd1
`endif
`ifndef SDB_WAIT
`define SDB_WAIT 2'd2
`endif

package store_drain_buffer_pkg;

    localparam int SDB_ADDR_W = `Addr_Width;
    localparam int SDB_DATA_W = `Data_Width;
    localparam int SDB_DEPTH  = `SDB_Depth;
    localparam int SDB_PTR_W  = $clog2(SDB_DEPTH);

    // Drain FSM: IDLE picks up the head, REQ holds it until ack, WAIT is the bubble.
    typedef enum logic [1:0] {
        IDLE = `SDB_IDLE,
        REQ  = `SDB_REQ,
        WAIT = `SDB_WAIT
    } sdb_state_e;

endpackage

// File: rtl/store_drain_buffer_fifo.sv
// In-order store FIFO: entry storage, pointers, occupancy count and the
// per-entry word-address compare vector used by the load hazard check.
module sdb_fifo
    import store_drain_buffer_pkg::*;
#(
    parameter int DEPTH     = SDB_DEPTH,
    parameter int PTR_WIDTH = SDB_PTR_W,
    parameter int ADDR_W    = SDB_ADDR_W,
    parameter int DATA_W    = SDB_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_W-1:0]     push_addr,
    input  logic [DATA_W-1:0]     push_data,
    input  logic [3:0]            push_mask,
    input  logic                  pop,
    input  logic [ADDR_W-3:0]     ld_word,
    output logic [ADDR_W-1:0]     head_addr,
    output logic [DATA_W-1:0]     head_data,
    output logic [3:0]            head_mask,
    output logic [PTR_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      match_vec
);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0][3:0]        mask_q, mask_d;
    logic [PTR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]           count_q, count_d;

    // Next-state for storage, pointers and count; pointers wrap naturally.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        mask_d   = mask_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            mask_d[wr_ptr_q] = push_mask;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every buffered store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // An entry is occupied when its distance from the head is below count;
    // the in-flight head stays occupied until its ack pops it.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = ({1'b0, PTR_WIDTH'(i) - rd_ptr_q} < count_q) &&
                           (mask_q[i] != 4'b0000) &&
                           (addr_q[i][ADDR_W-1:2] == ld_word);
        end
    end

    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign head_mask = mask_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == (PTR_WIDTH+1)'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/store_drain_buffer.sv
// Commit-side store drain buffer: accepts retired masked stores, queues them
// in order and writes them to memory one at a time over req/ack.
module store_drain_buffer
    import store_drain_buffer_pkg::*;
#(
    parameter int DEPTH     = SDB_DEPTH,
    parameter int PTR_WIDTH = SDB_PTR_W,
    parameter int ADDR_W    = SDB_ADDR_W,
    parameter int DATA_W    = SDB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dcache_write,
    input  logic [3:0]        dcache_mask,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_data,
    output logic              dcache_write_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [3:0]        mem_mask,
    input  logic              mem_ack,
    input  logic              ld_check,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic              empty
);

    logic              accept, push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [3:0]        head_mask;
    logic [PTR_WIDTH:0] count;
    logic              fifo_full, fifo_empty;
    logic [DEPTH-1:0]  match_vec;
    logic              unused_addr_bits;

    sdb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [3:0]        mem_mask_q, mem_mask_d;

    // Ready depends only on the registered count: a pop this cycle does not
    // free a slot until the next one.
    assign dcache_write_valid = !fifo_full;
    assign accept             = dcache_write && dcache_write_valid;
    // Empty-mask stores are acknowledged but never written.
    assign push               = accept && (dcache_mask != 4'b0000);

    // Word granularity: the low address bits never take part.
    assign unused_addr_bits = ^{dcache_addr[1:0], ld_addr[1:0]};

    sdb_fifo #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr ({dcache_addr[ADDR_W-1:2], 2'b00}),
        .push_data (dcache_data),
        .push_mask (dcache_mask),
        .pop       (pop),
        .ld_word   (ld_addr[ADDR_W-1:2]),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_mask (head_mask),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .match_vec (match_vec)
    );

    // Drain FSM next-state and output-register loads; head held through REQ.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_mask_d = mem_mask_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = head_addr;
                    mem_data_d = head_data;
                    mem_mask_d = head_mask;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    pop       = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and memory-side output registers; reset drops mem_req at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_mask_q <= mem_mask_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_mask = mem_mask_q;

    // Hazard: any occupied entry, or the store entering this very cycle.
    assign ld_hit = ld_check &&
                    ((|match_vec) ||
                     (push && (dcache_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])));

    assign empty = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-based model of the store buffer.
module tb_store_drain_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam logic [31:0] DK = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dcache_write = 1'b0;
    logic [3:0]    dcache_mask = '0;
    logic [AW-1:0] dcache_addr = '0;
    logic [DW-1:0] dcache_data = '0;
    logic          dcache_write_valid;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [3:0]    mem_mask;
    logic          mem_ack = 1'b0;
    logic          ld_check = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic          ld_hit;
    logic          empty;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    m;
    } st_t;

    always #10 clk = ~clk;

    store_drain_buffer #(
        .DEPTH(DEPTH), .PTR_WIDTH(2), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dcache_write       (dcache_write),
        .dcache_mask        (dcache_mask),
        .dcache_addr        (dcache_addr),
        .dcache_data        (dcache_data),
        .dcache_write_valid (dcache_write_valid),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_data           (mem_data),
        .mem_mask           (mem_mask),
        .mem_ack            (mem_ack),
        .ld_check           (ld_check),
        .ld_addr            (ld_addr),
        .ld_hit             (ld_hit),
        .empty              (empty)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one full cycle, returning just after the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        dcache_write = 1'b1;
        dcache_addr  = a;
        dcache_data  = d;
        dcache_mask  = m;
        cyc();
        dcache_write = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        #1;
        while (!mem_req && n < 12) begin
            cyc();
            #1;
            n++;
        end
        chk(tag, mem_req, 1'b1);
    endtask

    // Wait for the next request, check it, ack it for one edge.
    task automatic drain_one(input string tag, input logic [AW-1:0] a);
        wait_req({tag, "_req"});
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_data"}, mem_data, a ^ DK);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_t q[$];
        st_t e;
        bit  in_wait;
        bit  req_s, acc, psh, hit;
        int  stall;
        bit  seen_req;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_valid", dcache_write_valid, 1'b1);
        chk("rst_empty", empty, 1'b1);
        rst_n = 1'b1;
        cyc();

        // Single store: request appears two edges after accept
        put(32'h100, 32'h0000_AB00, 4'b0010);
        #1;
        chk("single_req_early", mem_req, 1'b0);
        cyc();
        #1;
        chk("single_req", mem_req, 1'b1);
        chk("single_addr", mem_addr, 32'h100);
        chk("single_data", mem_data, 32'h0000_AB00);
        chk("single_mask", mem_mask, 4'b0010);
        cyc();
        cyc();
        #1;
        chk("single_req_held", mem_req, 1'b1);
        chk("single_addr_held", mem_addr, 32'h100);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("single_req_drop", mem_req, 1'b0);
        chk("single_empty_wait", empty, 1'b0);
        cyc();
        #1;
        chk("single_empty", empty, 1'b1);

        // Fill to full, then refuse a fifth store
        for (int i = 0; i < 4; i++) put(32'(i * 4), 32'(i * 4) ^ DK, 4'hF);
        #1;
        chk("full_valid", dcache_write_valid, 1'b0);
        put(32'h10, 32'h10 ^ DK, 4'hF);
        #1;
        chk("full_valid_still", dcache_write_valid, 1'b0);
        chk("full_head_addr", mem_addr, 32'h0);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("full_valid_after_pop", dcache_write_valid, 1'b1);
        drain_one("full_1", 32'h4);
        drain_one("full_2", 32'h8);
        drain_one("full_3", 32'hC);
        cyc();
        #1;
        chk("full_no_fifth", empty, 1'b1);

        // Load hazard against a pending store
        put(32'h204, 32'h204 ^ DK, 4'hF);
        ld_check = 1'b1;
        ld_addr  = 32'h206;
        #1;
        chk("hz_same_word", ld_hit, 1'b1);
        ld_addr = 32'h208;
        #1;
        chk("hz_next_word", ld_hit, 1'b0);
        ld_addr  = 32'h206;
        ld_check = 1'b0;
        #1;
        chk("hz_no_check", ld_hit, 1'b0);
        drain_one("hz_drain", 32'h204);
        cyc();
        #1;
        chk("hz_empty", empty, 1'b1);
        // Same-cycle accept with an empty buffer
        dcache_write = 1'b1;
        dcache_addr  = 32'h204;
        dcache_data  = 32'h204 ^ DK;
        dcache_mask  = 4'b0001;
        ld_check     = 1'b1;
        ld_addr      = 32'h206;
        #1;
        chk("hz_bypass", ld_hit, 1'b1);
        cyc();
        dcache_write = 1'b0;
        ld_check     = 1'b0;
        drain_one("hz_bypass_drain", 32'h204);
        cyc();

        // Simultaneous accept and pop at count 3 with write pointer wrap
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) put(32'h400 + 32'(i * 4), (32'h400 + 32'(i * 4)) ^ DK, 4'hF);
        wait_req("wrap_req");
        chk("wrap_head", mem_addr, 32'h400);
        dcache_write = 1'b1;
        dcache_addr  = 32'h40C;
        dcache_data  = 32'h40C ^ DK;
        dcache_mask  = 4'hF;
        mem_ack      = 1'b1;
        cyc();
        dcache_write = 1'b0;
        mem_ack      = 1'b0;
        #1;
        chk("wrap_valid_cnt3", dcache_write_valid, 1'b1);
        put(32'h410, 32'h410 ^ DK, 4'hF);
        #1;
        chk("wrap_valid_cnt4", dcache_write_valid, 1'b0);
        drain_one("wrap_1", 32'h404);
        drain_one("wrap_2", 32'h408);
        drain_one("wrap_3", 32'h40C);
        drain_one("wrap_4", 32'h410);
        cyc();
        #1;
        chk("wrap_empty", empty, 1'b1);

        // Zero mask: taken but never written
        dcache_write = 1'b1;
        dcache_addr  = 32'h500;
        dcache_mask  = 4'b0000;
        ld_check     = 1'b1;
        ld_addr      = 32'h500;
        #1;
        chk("zm_valid", dcache_write_valid, 1'b1);
        chk("zm_no_hit", ld_hit, 1'b0);
        cyc();
        dcache_write = 1'b0;
        ld_check     = 1'b0;
        seen_req     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (mem_req) seen_req = 1'b1;
            cyc();
        end
        chk("zm_no_req", seen_req, 1'b0);
        #1;
        chk("zm_empty", empty, 1'b1);

        // Reset mid-drain
        put(32'h600, 32'h600 ^ DK, 4'hF);
        put(32'h604, 32'h604 ^ DK, 4'hF);
        wait_req("rmd_req");
        rst_n = 1'b0;
        #1;
        chk("rmd_req_async", mem_req, 1'b0);
        chk("rmd_empty_low", empty, 1'b1);
        chk("rmd_valid_low", dcache_write_valid, 1'b1);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rmd_empty", empty, 1'b1);
        chk("rmd_valid", dcache_write_valid, 1'b1);
        mem_ack = 1'b1;
        cyc();
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("rmd_ack_ignored_req", mem_req, 1'b0);
        chk("rmd_ack_ignored_empty", empty, 1'b1);
        cyc();

        // Randomized run against the queue model
        in_wait = 1'b0;
        stall   = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            dcache_write = ($urandom_range(0, 2) != 0);
            dcache_mask  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            dcache_addr  = 32'h300 + 32'($urandom_range(0, 7) * 4);
            dcache_data  = $urandom;
            mem_ack      = ($urandom_range(0, 1) == 1);
            ld_check     = ($urandom_range(0, 1) == 1);
            ld_addr      = 32'h300 + 32'($urandom_range(0, 35));
            #1;
            chk("rnd_valid", dcache_write_valid, q.size() != DEPTH);
            acc = dcache_write && (q.size() != DEPTH);
            psh = acc && (dcache_mask != 4'b0000);
            hit = 1'b0;
            if (ld_check) begin
                foreach (q[i]) if (q[i].a[AW-1:2] == ld_addr[AW-1:2]) hit = 1'b1;
                if (psh && dcache_addr[AW-1:2] == ld_addr[AW-1:2]) hit = 1'b1;
            end
            chk("rnd_ld_hit", ld_hit, hit);
            chk("rnd_empty", empty, (q.size() == 0) && !in_wait);
            req_s = mem_req;
            if (req_s) begin
                if (q.size() == 0) begin
                    chk("rnd_req_nothing_pending", 1'b1, 1'b0);
                end else begin
                    chk("rnd_mem_addr", mem_addr, q[0].a);
                    chk("rnd_mem_data", mem_data, q[0].d);
                    chk("rnd_mem_mask", mem_mask, q[0].m);
                end
            end
            stall = (q.size() > 0 && !req_s) ? stall + 1 : 0;
            chk("rnd_drain_stall", stall <= 2, 1'b1);
            @(posedge clk);
            in_wait = 1'b0;
            if (req_s && mem_ack) begin
                void'(q.pop_front());
                in_wait = 1'b1;
            end
            if (psh) begin
                e.a = {dcache_addr[AW-1:2], 2'b00};
                e.d = dcache_data;
                e.m = dcache_mask;
                q.push_back(e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
